cdb_arbiter: RTL and testbench

//  Transmit end of the common data bus (CDB). Collects finished results from
//  NUM_SRC functional units, buffers one result per source and broadcasts at

---
 rtl/data_types.sv | 25 ++
 rtl/cdb_arbiter_rr_pick.sv | 29 ++
 rtl/cdb_arbiter.sv | 79 +++++++
 tb/tb_cdb_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_types.sv
// Shared datapath types: RS tags, 32-bit words, the CDB payload and the CDB
// source index.
package data_types;
    localparam int CDB_NUM_SRC = 4;

    typedef logic [31:0] word32_t;

    typedef enum logic [2:0] {
        NO_VAL = 3'd0,
        ALU_1  = 3'd1,
        ALU_2  = 3'd2,
        ALU_3  = 3'd3,
        MUL_1  = 3'd4,
        MUL_2  = 3'd5,
        LD_1   = 3'd6,
        LD_2   = 3'd7
    } rs_tag_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    typedef logic [$clog2(CDB_NUM_SRC)-1:0] cdb_src_idx_t;
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester at index >= ptr,
// wrapping at N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] gidx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    always_comb begin
        int j;
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                gidx     = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: one holding slot per functional unit, round-robin
// selection, registered {tag,val} broadcast.
module cdb_arbiter
    import data_types::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic    [NUM_SRC-1:0]              fu_valid_i,
    input  rs_tag_t [NUM_SRC-1:0]              fu_tag_i,
    input  word32_t [NUM_SRC-1:0]              fu_val_i,
    output logic    [NUM_SRC-1:0]              fu_ready_o,
    output cdb_t                               cdb_o,
    output logic    [$clog2(NUM_SRC)-1:0]      cdb_src_o,
    output logic    [$clog2(NUM_SRC+1)-1:0]    pend_cnt_o
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = $clog2(NUM_SRC+1);

    logic    [NUM_SRC-1:0] full;
    logic    [NUM_SRC-1:0] grant;
    logic    [NUM_SRC-1:0] take;
    logic                  full_q   [NUM_SRC];
    rs_tag_t               slot_tag [NUM_SRC];
    word32_t               slot_val [NUM_SRC];
    logic    [SW-1:0]      rr_ptr;
    logic    [SW-1:0]      gidx;
    logic                  any;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req   (full),
        .ptr   (rr_ptr),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
        // A granted slot drains this cycle, so it may accept a new result.
        assign fu_ready_o[k] = (!full_q[k] || grant[k]) && reset_ni;
        assign take[k]       = fu_valid_i[k] && fu_ready_o[k];
        assign full[k]       = full_q[k];

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                full_q[k]   <= 1'b0;
                slot_tag[k] <= NO_VAL;
                slot_val[k] <= '0;
            end else if (take[k] && fu_tag_i[k] != NO_VAL) begin
                full_q[k]   <= 1'b1;
                slot_tag[k] <= fu_tag_i[k];
                slot_val[k] <= fu_val_i[k];
            end else if (grant[k]) begin
                full_q[k]   <= 1'b0;
            end
        end
    end

    always_comb begin
        pend_cnt_o = '0;
        for (int k = 0; k < NUM_SRC; k++)
            pend_cnt_o = pend_cnt_o + PW'(full[k]);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr    <= '0;
            cdb_o     <= '{tag: NO_VAL, val: '0};
            cdb_src_o <= '0;
        end else if (any) begin
            rr_ptr    <= (gidx == SW'(NUM_SRC-1)) ? '0 : gidx + 1'b1;
            cdb_o     <= '{tag: slot_tag[gidx], val: slot_val[gidx]};
            cdb_src_o <= gidx;
        end else begin
            cdb_o     <= '{tag: NO_VAL, val: '0};
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, full contention,
// streaming source vs. held slot, drain+refill and dropped NO_VAL results.
module tb_cdb_arbiter;
    import data_types::*;

    logic                   clk_i = 1'b0;
    logic                   reset_ni;
    logic    [3:0]          fu_valid_i;
    rs_tag_t [3:0]          fu_tag_i;
    word32_t [3:0]          fu_val_i;
    logic    [3:0]          fu_ready_o;
    cdb_t                   cdb_o;
    logic    [1:0]          cdb_src_o;
    logic    [2:0]          pend_cnt_o;

    int tests = 0;
    int fails = 0;

    cdb_arbiter #(.NUM_SRC(4)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .fu_valid_i (fu_valid_i),
        .fu_tag_i   (fu_tag_i),
        .fu_val_i   (fu_val_i),
        .fu_ready_o (fu_ready_o),
        .cdb_o      (cdb_o),
        .cdb_src_o  (cdb_src_o),
        .pend_cnt_o (pend_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        fu_valid_i = '0;
        for (int k = 0; k < 4; k++) begin
            fu_tag_i[k] = NO_VAL;
            fu_val_i[k] = '0;
        end
    endtask

    task automatic apply_reset();
        reset_ni = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset_ni = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        clear_inputs();
        tick();
        tests++;
        if (cdb_o.tag !== NO_VAL || cdb_o.val !== 32'd0 || cdb_src_o !== 2'd0 || pend_cnt_o !== 3'd0 || fu_ready_o !== 4'h0) begin
            fails++;
            $display("FAIL reset_state tag=%0d val=%h src=%0d pend=%0d ready=%b (want 0,0,0,0,0000)",
                     cdb_o.tag, cdb_o.val, cdb_src_o, pend_cnt_o, fu_ready_o);
        end
        reset_ni = 1'b1;
        tick();
        tests++;
        if (fu_ready_o !== 4'hF || pend_cnt_o !== 3'd0) begin
            fails++;
            $display("FAIL reset_release ready=%b pend=%0d (want 1111,0)", fu_ready_o, pend_cnt_o);
        end
        // load slot 2 then pull reset while it is full
        fu_valid_i[2] = 1'b1; fu_tag_i[2] = LD_1; fu_val_i[2] = 32'h55;
        tick();
        clear_inputs();
        #1;
        tests++;
        if (pend_cnt_o !== 3'd1) begin
            fails++;
            $display("FAIL reset_preload pend=%0d (want 1)", pend_cnt_o);
        end
        reset_ni = 1'b0;
        #1;
        tests++;
        if (cdb_o.tag !== NO_VAL || fu_ready_o !== 4'h0 || pend_cnt_o !== 3'd0) begin
            fails++;
            $display("FAIL reset_async tag=%0d ready=%b pend=%0d (want 0,0000,0)", cdb_o.tag, fu_ready_o, pend_cnt_o);
        end
        tick();
        reset_ni = 1'b1;
        #1;
        tests++;
        if (fu_ready_o !== 4'hF || pend_cnt_o !== 3'd0) begin
            fails++;
            $display("FAIL reset_after ready=%b pend=%0d (want 1111,0)", fu_ready_o, pend_cnt_o);
        end
        tick();
        tests++;
        if (cdb_o.tag !== NO_VAL || cdb_o.val !== 32'd0) begin
            fails++;
            $display("FAIL reset_no_partial tag=%0d val=%h (want idle)", cdb_o.tag, cdb_o.val);
        end
    endtask

    task automatic test_single();
        apply_reset();
        fu_valid_i[1] = 1'b1; fu_tag_i[1] = ALU_1; fu_val_i[1] = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        tests++;
        if (cdb_o.tag !== NO_VAL || pend_cnt_o !== 3'd1) begin
            fails++;
            $display("FAIL single_cycle1 tag=%0d pend=%0d (want 0,1)", cdb_o.tag, pend_cnt_o);
        end
        tick();
        tests++;
        if (cdb_o.tag !== ALU_1 || cdb_o.val !== 32'hDEAD_BEEF || cdb_src_o !== 2'd1 || pend_cnt_o !== 3'd0) begin
            fails++;
            $display("FAIL single_bcast tag=%0d val=%h src=%0d pend=%0d (want 1,deadbeef,1,0)",
                     cdb_o.tag, cdb_o.val, cdb_src_o, pend_cnt_o);
        end
        tick();
        tests++;
        if (cdb_o.tag !== NO_VAL || cdb_o.val !== 32'd0 || cdb_src_o !== 2'd1) begin
            fails++;
            $display("FAIL single_idle tag=%0d val=%h src=%0d (want 0,0,1 held)", cdb_o.tag, cdb_o.val, cdb_src_o);
        end
    endtask

    task automatic test_all_valid();
        rs_tag_t tags [4];
        tags[0] = ALU_1; tags[1] = ALU_2; tags[2] = MUL_1; tags[3] = MUL_2;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            fu_valid_i[k] = 1'b1; fu_tag_i[k] = tags[k]; fu_val_i[k] = 32'h100 + k;
        end
        tick();
        clear_inputs();
        tests++;
        if (pend_cnt_o !== 3'd4 || cdb_o.tag !== NO_VAL) begin
            fails++;
            $display("FAIL all_loaded pend=%0d tag=%0d (want 4,0)", pend_cnt_o, cdb_o.tag);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (cdb_src_o !== 2'(k) || cdb_o.tag !== tags[k] || cdb_o.val !== 32'h100 + k || pend_cnt_o !== 3'(3 - k)) begin
                fails++;
                $display("FAIL all_order%0d src=%0d tag=%0d val=%h pend=%0d (want %0d,%0d,%h,%0d)",
                         k, cdb_src_o, cdb_o.tag, cdb_o.val, pend_cnt_o, k, tags[k], 32'h100 + k, 3 - k);
            end
        end
        tick();
        tests++;
        if (cdb_o.tag !== NO_VAL) begin
            fails++;
            $display("FAIL all_idle tag=%0d (want 0)", cdb_o.tag);
        end
    endtask

    // rr_ptr is 0 on entry (last grant was src3)
    task automatic test_no_starve();
        fu_valid_i[0] = 1'b1; fu_tag_i[0] = ALU_2; fu_val_i[0] = 32'hA0;
        fu_valid_i[2] = 1'b1; fu_tag_i[2] = LD_2;  fu_val_i[2] = 32'h20;
        tick();
        fu_valid_i[2] = 1'b0; fu_tag_i[2] = NO_VAL;
        fu_val_i[0] = 32'hA1;
        #1;
        tests++;
        if (fu_ready_o[0] !== 1'b1 || pend_cnt_o !== 3'd2) begin
            fails++;
            $display("FAIL starve_c1 ready0=%b pend=%0d (want 1,2)", fu_ready_o[0], pend_cnt_o);
        end
        tick();
        tests++;
        if (cdb_o.val !== 32'hA0 || cdb_src_o !== 2'd0) begin
            fails++;
            $display("FAIL starve_b0 val=%h src=%0d (want a0,0)", cdb_o.val, cdb_src_o);
        end
        fu_val_i[0] = 32'hA2;
        #1;
        tests++;
        if (fu_ready_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL starve_bp ready0=%b (want 0)", fu_ready_o[0]);
        end
        tick();
        tests++;
        if (cdb_o.val !== 32'h20 || cdb_o.tag !== LD_2 || cdb_src_o !== 2'd2) begin
            fails++;
            $display("FAIL starve_b2 val=%h tag=%0d src=%0d (want 20,7,2)", cdb_o.val, cdb_o.tag, cdb_src_o);
        end
        tests++;
        if (fu_ready_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL starve_c3 ready0=%b (want 1)", fu_ready_o[0]);
        end
        tick();
        clear_inputs();
        tests++;
        if (cdb_o.val !== 32'hA1 || cdb_src_o !== 2'd0) begin
            fails++;
            $display("FAIL starve_b3 val=%h src=%0d (want a1,0)", cdb_o.val, cdb_src_o);
        end
        tick();
        tests++;
        if (cdb_o.val !== 32'hA2 || cdb_src_o !== 2'd0 || pend_cnt_o !== 3'd0) begin
            fails++;
            $display("FAIL starve_b4 val=%h src=%0d pend=%0d (want a2,0,0)", cdb_o.val, cdb_src_o, pend_cnt_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        fu_valid_i[3] = 1'b1; fu_tag_i[3] = MUL_2; fu_val_i[3] = 32'd5;
        tick();
        fu_val_i[3] = 32'd6;
        #1;
        tests++;
        if (fu_ready_o[3] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready3 ready=%b (want 1)", fu_ready_o[3]);
        end
        tick();
        clear_inputs();
        tests++;
        if (cdb_o.val !== 32'd5 || cdb_src_o !== 2'd3 || cdb_o.tag !== MUL_2) begin
            fails++;
            $display("FAIL b2b_first val=%0d src=%0d tag=%0d (want 5,3,5)", cdb_o.val, cdb_src_o, cdb_o.tag);
        end
        tick();
        tests++;
        if (cdb_o.val !== 32'd6 || cdb_src_o !== 2'd3 || cdb_o.tag !== MUL_2) begin
            fails++;
            $display("FAIL b2b_second val=%0d src=%0d tag=%0d (want 6,3,5)", cdb_o.val, cdb_src_o, cdb_o.tag);
        end
        tick();
        tests++;
        if (cdb_o.tag !== NO_VAL || pend_cnt_o !== 3'd0) begin
            fails++;
            $display("FAIL b2b_idle tag=%0d pend=%0d (want 0,0)", cdb_o.tag, pend_cnt_o);
        end
    endtask

    task automatic test_drop_noval();
        fu_valid_i[1] = 1'b1; fu_tag_i[1] = NO_VAL; fu_val_i[1] = 32'd7;
        #1;
        tests++;
        if (fu_ready_o[1] !== 1'b1) begin
            fails++;
            $display("FAIL drop_ready ready1=%b (want 1)", fu_ready_o[1]);
        end
        tick();
        clear_inputs();
        tests++;
        if (pend_cnt_o !== 3'd0 || cdb_o.val === 32'd7) begin
            fails++;
            $display("FAIL drop_c1 pend=%0d val=%0d (want 0, not 7)", pend_cnt_o, cdb_o.val);
        end
        tick();
        tests++;
        if (pend_cnt_o !== 3'd0 || cdb_o.tag !== NO_VAL || cdb_o.val !== 32'd0) begin
            fails++;
            $display("FAIL drop_c2 pend=%0d tag=%0d val=%0d (want 0,0,0)", pend_cnt_o, cdb_o.tag, cdb_o.val);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_no_starve();
        test_back_to_back();
        test_drop_noval();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
